// File: rtl/connect4_pkg.sv
// Shared Connect-4 types and constants for the move path between the Arduino
// link and the game FSM.
package connect4_pkg;

  localparam int NUM_COLS = 7;

  typedef logic [2:0] col_t;

  localparam byte ASCII_COL0 = 8'h30;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/arduino_move_rx_uart.sv
// 8N1 UART receiver: 2-FF synchroniser, start-edge detect, mid-bit sampling.
// Emits a one-cycle byte_valid_o or frame_err_o pulse per completed frame.
module uart_rx_8n1
  import connect4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] data_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       sync_q;
  logic             rx_prev_q;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_s;

  assign rx_s = sync_q[1];

  // Synchroniser and edge-history flops preset high so reset looks like an idle line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      rx_prev_q    <= rx_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d   = RX_START;
          bit_idx_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          state_d      = RX_IDLE;
          byte_valid_d = rx_s;
          frame_err_d  = !rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign data_o       = shift_q;
  assign busy_o       = (state_q != RX_IDLE);

endmodule

// File: rtl/arduino_move_rx.sv
// Player-2 move receiver: ASCII column digits from the Arduino UART become
// moves held in a one-entry valid/ready buffer; bad traffic is flagged and dropped.
module arduino_move_rx
  import connect4_pkg::col_t;
  import connect4_pkg::ASCII_COL0;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int NUM_COLS = connect4_pkg::NUM_COLS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arduino_rx,
  input  logic       accept_en,
  input  logic       col_ready,
  output logic       col_valid,
  output logic [2:0] col_index,
  output logic       frame_err,
  output logic       bad_char,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [7:0] COL0         = 8'(ASCII_COL0);
  localparam logic [7:0] NCOLS        = 8'(NUM_COLS);

  logic       byte_valid;
  logic [7:0] rx_data;
  logic [7:0] offset;
  logic       legal;

  logic col_valid_q, col_valid_d;
  col_t col_index_q, col_index_d;
  logic bad_char_q, bad_char_d;
  logic overrun_q, overrun_d;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (arduino_rx),
    .byte_valid_o(byte_valid),
    .data_o      (rx_data),
    .frame_err_o (frame_err),
    .busy_o      (rx_busy)
  );

  assign offset = rx_data - COL0;
  assign legal  = (rx_data >= COL0) && (offset < NCOLS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_valid_q <= 1'b0;
      col_index_q <= '0;
      bad_char_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      col_valid_q <= col_valid_d;
      col_index_q <= col_index_d;
      bad_char_q  <= bad_char_d;
      overrun_q   <= overrun_d;
    end
  end

  // Decode sees the buffer as it was this cycle, so a same-cycle consume still overruns.
  always_comb begin
    col_valid_d = col_valid_q;
    col_index_d = col_index_q;
    bad_char_d  = 1'b0;
    overrun_d   = 1'b0;
    if (col_valid_q && (col_ready || !accept_en)) col_valid_d = 1'b0;
    if (byte_valid) begin
      if (!legal) begin
        bad_char_d = 1'b1;
      end else if (accept_en) begin
        if (col_valid_q) begin
          overrun_d = 1'b1;
        end else begin
          col_valid_d = 1'b1;
          col_index_d = col_t'(offset[2:0]);
        end
      end
    end
  end

  assign col_valid = col_valid_q;
  assign col_index = col_index_q;
  assign bad_char  = bad_char_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_arduino_move_rx.sv
// Directed bench for arduino_move_rx at a reduced bit time (16 clocks per bit).
`timescale 1ns/1ps
module tb_arduino_move_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       arduino_rx;
  logic       accept_en;
  logic       col_ready;
  logic       col_valid;
  logic [2:0] col_index;
  logic       frame_err;
  logic       bad_char;
  logic       overrun;
  logic       rx_busy;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int rise_cnt = 0;
  int fe_cyc = 0;
  int bc_cyc = 0;
  int ov_cyc = 0;
  logic cv_prev = 1'b0;

  arduino_move_rx #(
    .CLK_FREQ(CPB * 10),
    .BAUD    (10),
    .NUM_COLS(7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arduino_rx(arduino_rx),
    .accept_en (accept_en),
    .col_ready (col_ready),
    .col_valid (col_valid),
    .col_index (col_index),
    .frame_err (frame_err),
    .bad_char  (bad_char),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Pulse/level monitor: counts flag-high cycles and col_valid rising edges.
  always @(negedge clk) begin
    if (frame_err) fe_cyc = fe_cyc + 1;
    if (bad_char)  bc_cyc = bc_cyc + 1;
    if (overrun)   ov_cyc = ov_cyc + 1;
    if (col_valid && !cv_prev) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    cv_prev = col_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    arduino_rx = 1'b0;
    start_cyc  = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      arduino_rx = b[i];
      tick(CPB);
    end
    arduino_rx = stop_val;
    tick(CPB);
    arduino_rx = 1'b1;
    tick(4);
  endtask

  task automatic consume();
    col_ready = 1'b1;
    tick(1);
    col_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] b;
    rst        = 1'b1;
    arduino_rx = 1'b1;
    accept_en  = 1'b1;
    col_ready  = 1'b0;
    tick(3);
    @(negedge clk);
    check("reset_outputs", {26'd0, col_valid, col_index, frame_err, bad_char, overrun, rx_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(3);

    // '4': latency is 9.5 bit times +/- 4 clocks from the start edge
    send_byte(8'h34, 1'b1);
    lat = rise_cyc - start_cyc;
    check("t1_latency_in_window", {31'd0, (lat >= CPB * 19 / 2 - 4) && (lat <= CPB * 19 / 2 + 4)}, 32'd1);
    check("t1_col_valid", {31'd0, col_valid}, 32'd1);
    check("t1_col_index", {29'd0, col_index}, 32'd4);
    check("t1_idle_after_frame", {31'd0, rx_busy}, 32'd0);
    consume();
    check("t1_consumed", {31'd0, col_valid}, 32'd0);

    // '7' and 'A' are out of range
    send_byte(8'h37, 1'b1);
    send_byte(8'h41, 1'b1);
    check("t2_bad_char_cycles", bc_cyc, 32'd2);
    check("t2_no_new_move", rise_cnt, 32'd1);
    check("t2_col_valid", {31'd0, col_valid}, 32'd0);

    // short low glitch, shorter than half a bit
    arduino_rx = 1'b0;
    tick(4);
    check("t3_glitch_busy", {31'd0, rx_busy}, 32'd1);
    arduino_rx = 1'b1;
    tick(2 * CPB);
    check("t3_glitch_back_idle", {31'd0, rx_busy}, 32'd0);
    check("t3_glitch_no_flags", fe_cyc + bc_cyc + ov_cyc, 32'd2);
    send_byte(8'h30, 1'b1);
    check("t3_col0_valid", {31'd0, col_valid}, 32'd1);
    check("t3_col0_index", {29'd0, col_index}, 32'd0);
    consume();

    // '3' with a low stop bit
    send_byte(8'h33, 1'b0);
    check("t4_frame_err_cycles", fe_cyc, 32'd1);
    check("t4_col_valid", {31'd0, col_valid}, 32'd0);
    check("t4_no_bad_char", bc_cyc, 32'd2);

    // '1' then '5' with no consume: second is overrun
    send_byte(8'h31, 1'b1);
    send_byte(8'h35, 1'b1);
    check("t5_overrun_cycles", ov_cyc, 32'd1);
    check("t5_held_valid", {31'd0, col_valid}, 32'd1);
    check("t5_held_index", {29'd0, col_index}, 32'd1);
    consume();
    check("t5_consumed", {31'd0, col_valid}, 32'd0);

    accept_en = 1'b0;
    send_byte(8'h31, 1'b1);
    send_byte(8'h35, 1'b1);
    check("t5_gated_no_move", rise_cnt, 32'd3);
    check("t5_gated_no_flags", fe_cyc + bc_cyc + ov_cyc, 32'd4);
    send_byte(8'h41, 1'b1);
    check("t5_gated_bad_char", bc_cyc, 32'd3);
    accept_en = 1'b1;

    // pending '5', then reset in the middle of '2'
    send_byte(8'h35, 1'b1);
    check("t6_pre_index", {29'd0, col_index}, 32'd5);
    b = 8'h32;
    arduino_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      arduino_rx = b[i];
      tick(CPB);
    end
    check("t6_busy_mid_data", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    arduino_rx = 1'b1;
    #1;
    check("t6_reset_outputs", {26'd0, col_valid, col_index, frame_err, bad_char, overrun, rx_busy}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    send_byte(8'h36, 1'b1);
    check("t6_col6_valid", {31'd0, col_valid}, 32'd1);
    check("t6_col6_index", {29'd0, col_index}, 32'd6);
    accept_en = 1'b0;
    tick(1);
    check("t6_accept_drop_clears", {31'd0, col_valid}, 32'd0);
    check("t6_flag_totals", fe_cyc + bc_cyc + ov_cyc, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
